board_blitter: RTL and testbench
================================

// Module: board_blitter
// PURPOSE
//  Upstream feeder for the 16x16 sprite mapper. On each frame_start, walks the
//  game board (BOARD_COLS x BOARD_ROWS cells, 4-bit colour per cell) row-major,
//  reads each cell's colour from the board RAM, and launches one sprite draw per
//  cell: pixel origin, colour, and a start pulse, then waits for the draw to finish.
// PARAMETERS
//  BOARD_COLS  10   cells per row
//  BOARD_ROWS  20   rows per board
//  ORIGIN_X    240  framebuffer x of cell (0,0), pixels
//  ORIGIN_Y    80   framebuffer y of cell (0,0), pixels
//  SKIP_EMPTY  0    1: cells with colour 4'h0 are not drawn
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  reset        in   1   asynchronous, active-high
//  frame_start  in   1   1-cycle pulse: begin a full board redraw
//  cell_addr    out  8   board RAM read address = row*BOARD_COLS + col
//  cell_color   in   4   board RAM data, valid 1 cycle after cell_addr (sync read)
//  sm_x         out  10  sprite origin x = ORIGIN_X + col*16
//  sm_y         out  10  sprite origin y = ORIGIN_Y + row*16
//  sm_color     out  4   sprite colour (registered cell_color)
//  sm_start     out  1   sprite mapper start; mapper acts on its rising edge
//  sm_complete  in   1   mapper idle flag: high when waiting, low while drawing
//  busy         out  1   high from frame_start accept until frame_done
//  frame_done   out  1   1-cycle pulse after last cell's draw completes
// BEHAVIOUR
//  Reset: state IDLE; col=row=0; cell_addr, sm_x, sm_y, sm_color = 0;
//   sm_start, busy, frame_done = 0. Reset mid-frame aborts immediately; sm_start low.
//  All outputs registered. col 4b, row 5b; sm_x/sm_y = ORIGIN + (idx<<4), 10b, no wrap check.
//  States:
//   IDLE      frame_start=1 -> FETCH, col=row=0, busy=1. Else stay.
//   FETCH     drive cell_addr for (row,col) -> LATCH.
//   LATCH     capture cell_color into sm_color, load sm_x/sm_y.
//             SKIP_EMPTY=1 and cell_color==0 -> ADVANCE; else -> ISSUE.
//   ISSUE     sm_start=1 for exactly this cycle; sm_x/y/color stable -> WAIT_LOW.
//   WAIT_LOW  sm_complete==0 -> WAIT_HIGH; else stay (mapper not yet started).
//   WAIT_HIGH sm_complete==1 -> ADVANCE; else stay.
//   ADVANCE   col==BOARD_COLS-1: col=0, row++ ; else col++.
//             Last cell (row==BOARD_ROWS-1, col==BOARD_COLS-1) -> DONE; else -> FETCH.
//   DONE      frame_done=1, busy=0 on exit -> IDLE.
//  sm_start low in every state but ISSUE (guarantees a fresh edge per cell).
//  sm_x/sm_y/sm_color held from LATCH until next LATCH (mapper latches while idle).
//  frame_start while busy: ignored, not queued. frame_start in DONE cycle: ignored.
//  Timing with a 256-cycle mapper: FETCH f, ISSUE f+2, complete low f+3..f+258,
//   next FETCH f+261 -> 261 cycles/drawn cell, 3 cycles/skipped cell;
//   full 10x20 frame: frame_done 52200 cycles after first FETCH.
// TESTING
//  Reset: assert reset mid-WAIT_HIGH -> same cycle sm_start=0, busy=0, IDLE; next
//   frame_start restarts at cell_addr=0, sm_x=240, sm_y=80.
//  All cells colour 3, 256-cycle mapper model -> 200 sm_start pulses; cell 9 at
//   (384,80), cell 10 at (240,96), cell 199 at (384,384); frame_done 52200 cycles in.
//  SKIP_EMPTY=1, only cell 57 = 4'h5 -> exactly one sm_start, sm_x=352, sm_y=160,
//   sm_color=5; frame_done after 199*3+261 cycles.
//  frame_start pulsed during cell 20 draw -> ignored; exactly one frame_done.
//  Mapper model delays complete fall 3 cycles -> blitter holds WAIT_LOW, no re-issue,
//   sm_start single-cycle, all 200 cells drawn once.

Source files
------------

// File: rtl/board_blitter.sv
// Board-to-sprite feeder: on frame_start walks the board row-major, reads each cell
// colour from a sync-read RAM and hands one 16x16 draw per cell to the sprite mapper.
module board_blitter #(
    parameter int BOARD_COLS = 10,
    parameter int BOARD_ROWS = 20,
    parameter int ORIGIN_X   = 240,
    parameter int ORIGIN_Y   = 80,
    parameter int SKIP_EMPTY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    output logic [7:0] cell_addr,
    input  logic [3:0] cell_color,
    output logic [9:0] sm_x,
    output logic [9:0] sm_y,
    output logic [3:0] sm_color,
    output logic       sm_start,
    input  logic       sm_complete,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] LAST_COL = 4'(BOARD_COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(BOARD_ROWS - 1);
    localparam logic [9:0] X_BASE   = 10'(ORIGIN_X);
    localparam logic [9:0] Y_BASE   = 10'(ORIGIN_Y);
    localparam bit         SKIP_EN  = (SKIP_EMPTY != 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH,
        ADVANCE,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] col;
    logic [4:0] row;
    logic       last_cell;

    // Pixel origin of a cell along one axis: 16 pixels per cell, no wrap handling.
    function automatic logic [9:0] cell_px(input logic [9:0] base, input logic [4:0] idx);
        return base + {1'b0, idx, 4'b0000};
    endfunction

    assign last_cell = (row == LAST_ROW) && (col == LAST_COL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                state_nx = LATCH;
            end
            LATCH: begin
                if (SKIP_EN && (cell_color == 4'h0)) begin
                    state_nx = ADVANCE;
                end else begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                state_nx = WAIT_LOW;
            end
            // The mapper may take a few cycles to drop its idle flag; never re-issue meanwhile.
            WAIT_LOW: begin
                if (!sm_complete) begin
                    state_nx = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (sm_complete) begin
                    state_nx = ADVANCE;
                end
            end
            ADVANCE: begin
                if (last_cell) begin
                    state_nx = DONE;
                end else begin
                    state_nx = FETCH;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sm_start   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sm_start   <= (state_nx == ISSUE);
            busy       <= (state_nx != IDLE);
            frame_done <= (state_nx == DONE);
        end
    end

    // cell_addr is valid throughout FETCH, so the RAM data arrives in LATCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col       <= 4'd0;
            row       <= 5'd0;
            cell_addr <= 8'd0;
            sm_x      <= 10'd0;
            sm_y      <= 10'd0;
            sm_color  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        col       <= 4'd0;
                        row       <= 5'd0;
                        cell_addr <= 8'd0;
                    end
                end
                LATCH: begin
                    sm_color <= cell_color;
                    sm_x     <= cell_px(X_BASE, {1'b0, col});
                    sm_y     <= cell_px(Y_BASE, row);
                end
                ADVANCE: begin
                    cell_addr <= cell_addr + 8'd1;
                    if (col == LAST_COL) begin
                        col <= 4'd0;
                        row <= row + 5'd1;
                    end else begin
                        col <= col + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_blitter.sv
// Scoreboard bench for board_blitter: one plain instance and one SKIP_EMPTY instance,
// each with a sync-read board RAM and a behavioural sprite mapper.
module tb_board_blitter;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] c;
    } draw_t;

    typedef struct {
        int lat;
        int np;
    } done_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start [2];
    logic [7:0] cell_addr   [2];
    logic [3:0] cell_color  [2];
    logic [9:0] sm_x        [2];
    logic [9:0] sm_y        [2];
    logic [3:0] sm_color    [2];
    logic       sm_start    [2];
    logic       sm_complete [2];
    logic       busy        [2];
    logic       frame_done  [2];

    logic [3:0] ram [2][256];
    draw_t      sb_q[$];
    done_t      done_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int map_len = 256;
    int map_delay = 0;

    int   pulses    [2];
    int   fetch_cyc [2];
    int   hi_len    [2];
    logic busy_q    [2];
    logic st_q      [2];
    logic st_m      [2];
    logic pend      [2];
    int   dly       [2];
    int   run       [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        board_blitter #(.SKIP_EMPTY(g)) dut (
            .clk         (clk),
            .reset       (rst),
            .frame_start (frame_start[g]),
            .cell_addr   (cell_addr[g]),
            .cell_color  (cell_color[g]),
            .sm_x        (sm_x[g]),
            .sm_y        (sm_y[g]),
            .sm_color    (sm_color[g]),
            .sm_start    (sm_start[g]),
            .sm_complete (sm_complete[g]),
            .busy        (busy[g]),
            .frame_done  (frame_done[g])
        );
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Board RAM, one-cycle read latency
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) cell_color[g] <= ram[g][cell_addr[g]];
    end

    // Sprite mapper: on start rise, waits map_delay cycles, then drops complete for map_len cycles
    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                sm_complete[g] <= 1'b1;
                st_m[g]        <= 1'b0;
                pend[g]        <= 1'b0;
                dly[g]         <= 0;
                run[g]         <= 0;
            end else begin
                st_m[g] <= sm_start[g];
                if (sm_start[g] && !st_m[g]) begin
                    if (map_delay == 0) begin
                        sm_complete[g] <= 1'b0;
                        run[g]         <= map_len - 1;
                    end else begin
                        pend[g] <= 1'b1;
                        dly[g]  <= map_delay - 1;
                    end
                end else if (pend[g]) begin
                    if (dly[g] == 0) begin
                        pend[g]        <= 1'b0;
                        sm_complete[g] <= 1'b0;
                        run[g]         <= map_len - 1;
                    end else begin
                        dly[g] <= dly[g] - 1;
                    end
                end else if (!sm_complete[g]) begin
                    if (run[g] == 0) sm_complete[g] <= 1'b1;
                    else run[g] <= run[g] - 1;
                end
            end
        end
    end

    // Monitor: pops expected draws on each start rise, expected frame summary on frame_done
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                busy_q[g] = 1'b0;
                st_q[g]   = 1'b0;
                hi_len[g] = 0;
            end else begin
                if (busy[g] && !busy_q[g]) begin
                    fetch_cyc[g] = cyc;
                    pulses[g]    = 0;
                    chk("first_cell_addr", int'(cell_addr[g]), 0);
                end
                if (sm_start[g]) hi_len[g]++;
                if (!sm_start[g] && st_q[g]) begin
                    chk("start_width", hi_len[g], 1);
                    hi_len[g] = 0;
                end
                if (sm_start[g] && !st_q[g]) begin
                    pulses[g]++;
                    chk("draw_expected", int'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        draw_t d;
                        d = sb_q.pop_front();
                        chk("sm_x", int'(sm_x[g]), int'(d.x));
                        chk("sm_y", int'(sm_y[g]), int'(d.y));
                        chk("sm_color", int'(sm_color[g]), int'(d.c));
                    end
                end
                if (frame_done[g]) begin
                    chk("done_expected", int'(done_q.size() > 0), 1);
                    if (done_q.size() > 0) begin
                        done_t e;
                        e = done_q.pop_front();
                        chk("frame_latency", cyc - fetch_cyc[g], e.lat);
                        chk("draw_count", pulses[g], e.np);
                        chk("draws_left", sb_q.size(), 0);
                    end
                end
                busy_q[g] = busy[g];
                st_q[g]   = sm_start[g];
            end
        end
    end

    task automatic start_frame(input int g);
        @(negedge clk) frame_start[g] = 1'b1;
        @(negedge clk) frame_start[g] = 1'b0;
    endtask

    // Expected draw list straight from the board contents
    task automatic push_frame(input int g);
        draw_t d;
        for (int i = 0; i < 200; i++) begin
            if (g == 0 || ram[g][i] != 4'h0) begin
                d.x = 10'(240 + (i % 10) * 16);
                d.y = 10'(80 + (i / 10) * 16);
                d.c = ram[g][i];
                sb_q.push_back(d);
            end
        end
    endtask

    task automatic push_done(input int lat, input int np);
        done_t e;
        e.lat = lat;
        e.np  = np;
        done_q.push_back(e);
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (!frame_done[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!frame_done[g]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_done_timeout: got none, want pulse within %0d cycles", budget);
        end
    endtask

    task automatic wait_pulses(input int g, input int target, input int budget);
        int n = 0;
        while (pulses[g] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pulses[g] < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL start_timeout: got %0d pulses, want %0d", pulses[g], target);
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            frame_start[g] = 1'b0;
            pulses[g]      = 0;
            fetch_cyc[g]   = 0;
            for (int i = 0; i < 256; i++) ram[g][i] = 4'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_cell_addr", int'(cell_addr[g]), 0);
            chk("rst_sm_x", int'(sm_x[g]), 0);
            chk("rst_sm_y", int'(sm_y[g]), 0);
            chk("rst_sm_color", int'(sm_color[g]), 0);
            chk("rst_sm_start", int'(sm_start[g]), 0);
            chk("rst_busy", int'(busy[g]), 0);
            chk("rst_frame_done", int'(frame_done[g]), 0);
        end
        #2 rst = 1'b0;

        // Abort mid-draw: only cell 0 is ever issued
        for (int i = 0; i < 200; i++) ram[0][i] = 4'h3;
        map_len   = 256;
        map_delay = 0;
        push_frame(0);
        sb_q = sb_q[0:0];
        start_frame(0);
        wait_pulses(0, 1, 50);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_sm_start", int'(sm_start[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_cell_addr", int'(cell_addr[0]), 0);
        chk("abort_sm_x", int'(sm_x[0]), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_idle_busy", int'(busy[0]), 0);

        // Slow-falling mapper, distinct colours, stray frame_start during cell 20
        for (int i = 0; i < 200; i++) ram[0][i] = 4'(i);
        map_len   = 16;
        map_delay = 3;
        push_frame(0);
        push_done(200 * 24, 200);
        start_frame(0);
        wait_pulses(0, 21, 1000);
        repeat (5) @(negedge clk);
        start_frame(0);
        wait_done(0, 6000);
        repeat (40) @(negedge clk);
        chk("post_frame_busy", int'(busy[0]), 0);

        // Full board, colour 3, 256-cycle mapper
        for (int i = 0; i < 200; i++) ram[0][i] = 4'h3;
        map_len   = 256;
        map_delay = 0;
        push_frame(0);
        push_done(52200, 200);
        start_frame(0);
        wait_done(0, 53000);
        repeat (10) @(negedge clk);

        // Skip-empty board with a single coloured cell
        ram[1][57] = 4'h5;
        push_frame(1);
        push_done(199 * 3 + 261, 1);
        start_frame(1);
        wait_done(1, 2000);
        repeat (10) @(negedge clk);
        chk("skip_busy", int'(busy[1]), 0);

        chk("draws_pending", sb_q.size(), 0);
        chk("frames_pending", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
